// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets a fetch port and a data port share one single-port synchronous RAM.
// Writes finish in their grant cycle. Reads spend one wait cycle, then return data with an rvalid pulse.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;
  logic              r_rd_port;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_rd_grant;

  // Grants are gated by areset so that no grant can reach the RAM while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (areset && (r_state == IDLE)) begin
      if (if_req && d_req) begin
        w_if_gnt = (r_last_grant == PORT_D);
        w_d_gnt  = (r_last_grant == PORT_IF);
      end else begin
        w_if_gnt = if_req;
        w_d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_grant   = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    case (r_state)
      IDLE: begin
        if (w_if_gnt) begin
          ram_en       = 1'b1;
          ram_addr     = if_addr;
          w_rd_grant   = 1'b1;
          w_state_next = RD_WAIT;
        end else if (w_d_gnt) begin
          ram_en   = 1'b1;
          ram_addr = d_addr;
          if (d_we) begin
            ram_we  = 1'b1;
            ram_din = d_wdata;
          end else begin
            w_rd_grant   = 1'b1;
            w_state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_IF;
      r_rd_port    <= PORT_IF;
    end else begin
      r_state <= w_state_next;
      if (w_if_gnt) begin
        r_last_grant <= PORT_IF;
      end else if (w_d_gnt) begin
        r_last_grant <= PORT_D;
      end
      if (w_rd_grant) begin
        r_rd_port <= w_d_gnt ? PORT_D : PORT_IF;
      end
    end
  end

  // ram_dout is valid during RD_WAIT. It is captured into the port that issued the read.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= (r_state == RD_WAIT) && (r_rd_port == PORT_IF);
      r_d_rvalid  <= (r_state == RD_WAIT) && (r_rd_port == PORT_D);
      if (r_state == RD_WAIT) begin
        if (r_rd_port == PORT_IF) begin
          r_if_rdata <= ram_dout;
        end else begin
          r_d_rdata <= ram_dout;
        end
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: the bench attaches a RAM to the arbiter and compares each cycle
// against a transaction-level model (round-robin winner, memory image, pending read return).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       areset;
  logic       if_req, d_req, d_we;
  logic [3:0] if_addr, d_addr;
  logic [7:0] d_wdata;
  logic       if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [7:0] if_rdata, d_rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic       busy;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .areset(areset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM attached to the arbiter: synchronous write, registered read.
  logic [7:0] tb_ram [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) tb_ram[ram_addr] <= ram_din;
      ram_dout <= tb_ram[ram_addr];
    end
  end

  // Reference model state.
  logic [7:0] m_mem [16];
  logic       m_last;      // 0 = fetch granted last, 1 = data granted last
  logic       m_wait;      // a read is outstanding
  logic       m_rd_port;
  logic [7:0] m_rd_data;
  logic [7:0] m_if_rdata, m_d_rdata;
  logic       m_if_rv, m_d_rv;
  logic       g_if, g_d;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_last = 1'b0; m_rd_port = 1'b0; m_rd_data = 8'h00;
    m_if_rdata = 8'h00; m_d_rdata = 8'h00; m_if_rv = 1'b0; m_d_rv = 1'b0;
    g_if = 1'b0; g_d = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
  endtask

  // Inputs are set at the negedge. This task checks the current cycle, then advances to the next negedge.
  task automatic step();
    logic       e_if_gnt, e_d_gnt, e_we, e_any;
    logic [3:0] e_addr;
    #1;
    e_if_gnt = 1'b0;
    e_d_gnt  = 1'b0;
    if (!m_wait) begin
      if (if_req && d_req) begin
        e_if_gnt = m_last;
        e_d_gnt  = !m_last;
      end else begin
        e_if_gnt = if_req;
        e_d_gnt  = d_req;
      end
    end
    e_any  = e_if_gnt | e_d_gnt;
    e_addr = e_if_gnt ? if_addr : d_addr;
    e_we   = e_d_gnt & d_we;
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("busy", busy, m_wait);
    chk("ram_en", ram_en, e_any);
    chk("ram_we", ram_we, e_we);
    if (e_any) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_din", ram_din, e_we ? d_wdata : 8'h00);
      $display("[TB] t=%0t grant %s addr=%0h %s data=%0h", $time, e_if_gnt ? "fetch" : "data ",
               e_addr, e_we ? "WR" : "RD", e_we ? d_wdata : m_mem[e_addr]);
    end
    chk("if_rvalid", if_rvalid, m_if_rv);
    chk("d_rvalid", d_rvalid, m_d_rv);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    @(posedge clk);
    m_if_rv = 1'b0;
    m_d_rv  = 1'b0;
    g_if    = e_if_gnt;
    g_d     = e_d_gnt;
    if (m_wait) begin
      m_wait = 1'b0;
      if (m_rd_port) begin m_d_rdata = m_rd_data; m_d_rv = 1'b1; end
      else begin m_if_rdata = m_rd_data; m_if_rv = 1'b1; end
    end else if (e_any) begin
      m_last = e_d_gnt;
      if (e_we) m_mem[e_addr] = d_wdata;
      else begin
        m_wait    = 1'b1;
        m_rd_port = e_d_gnt;
        m_rd_data = m_mem[e_addr];
      end
    end
    @(negedge clk);
  endtask

  // Each requester holds its request until it is granted. Idle ports drive random (ignored) values.
  // mode 1: random new requests; mode 2: always re-request.
  task automatic gen(input int mode);
    if (g_if) if_req = 1'b0;
    if (g_d) d_req = 1'b0;
    if (!if_req) begin
      if_addr = 4'($urandom);
      if (mode == 2 || $urandom_range(0, 1) == 1) if_req = 1'b1;
    end
    if (!d_req) begin
      d_addr  = 4'($urandom);
      d_we    = 1'($urandom);
      d_wdata = 8'($urandom);
      if (mode == 2 || $urandom_range(0, 2) == 0) d_req = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    areset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 4'h0; d_addr = 4'h0; d_wdata = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    areset = 1'b1;

    // Write 5 <= A4, busy must stay low.
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'h5; d_wdata = 8'hA4;
    step();
    // Fill every other address so that later reads see known data.
    for (int a = 0; a < 16; a++) begin
      if (a != 5) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 4'(a); d_wdata = 8'($urandom);
        step();
      end
    end
    idle_inputs();
    step();

    // Fetch read of 5: grant at T, busy at T+1, rvalid with A4 at T+2.
    if_req = 1'b1; if_addr = 4'h5;
    step();
    if_req = 1'b0;
    step();
    step();
    chk("req019_if_rdata_model", m_if_rdata, 8'hA4);
    step();

    // Reset, then hold both requests: grants alternate d, if, d, if.
    areset = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    areset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      gen(2);
      step();
    end
    idle_inputs();
    g_if = 1'b0; g_d = 1'b0;
    step(); step();

    // Fetch read of 0xF. A data read is requested during the wait cycle and must wait until T+2.
    if_req = 1'b1; if_addr = 4'hF;
    step();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 4'h3;
    step();
    step();
    d_req = 1'b0;
    step(); step(); step();

    // Reset during the wait cycle of a read: no rvalid and no rdata update after release.
    if_req = 1'b1; if_addr = 4'h5;
    step();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 4'h5;
    areset = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    idle_inputs();
    areset = 1'b1;
    step(); step(); step();

    // Randomized traffic.
    g_if = 1'b0; g_d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      gen(1);
      step();
    end
    idle_inputs();
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
